// File: rtl/sys_defs.sv
// Shared memory-bus definitions: command and size encodings, tag width and the
// owner-table entry used by the memory arbiter.
`ifndef XLEN
`define XLEN 64
`endif

package sys_defs;

    localparam int MEM_TAG_W   = 4;
    localparam int MEM_OWNER_W = 8;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } MEM_SIZE;

    // Owner field is wide enough for any practical requester count.
    typedef struct packed {
        logic                   valid;
        logic [MEM_OWNER_W-1:0] owner;
    } MEM_OWNER_ENTRY;

endpackage

// File: rtl/mem_arbiter_nport_picker.sv
// Rotating first-set picker: scans the request vector starting at i_start,
// wrapping modulo N, and returns the first set position as a one-hot grant.
module rr_priority_picker #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_grant_oh,
    output logic          o_valid
);

    // first requester at or after i_start, wrapping around
    always_comb begin
        int w_idx;
        w_idx      = 0;
        o_grant_oh = '0;
        o_valid    = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(i_start) + k;
            w_idx = (w_idx >= N) ? (w_idx - N) : w_idx;
            if (i_req[IW'(w_idx)] && !o_valid) begin
                o_grant_oh[IW'(w_idx)] = 1'b1;
                o_valid                = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_nport.sv
// N-requester arbiter in front of the single-ported memory bus: forwards one
// command per cycle and steers returning load tags back to their owner.
`ifndef XLEN
`define XLEN 64
`endif

module mem_arbiter_nport
    import sys_defs::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int PRIO_MODE = 0,
    parameter  int MAX_WAIT  = 8,
    parameter  int TAG_W     = MEM_TAG_W,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0][`XLEN-1:0]      req_addr_in,
    input  logic [NUM_REQ-1:0][63:0]           req_data_in,
    input  logic [NUM_REQ-1:0][1:0]            req_command_in,
    input  logic [NUM_REQ-1:0][1:0]            req_size_in,
    output logic [NUM_REQ-1:0][TAG_W-1:0]      req_response_out,
    output logic [NUM_REQ-1:0][TAG_W-1:0]      req_tag_out,
    output logic [NUM_REQ-1:0][63:0]           req_data_out,
    input  logic [TAG_W-1:0]                   mem_tag_in,
    input  logic [63:0]                        mem_data_in,
    input  logic [TAG_W-1:0]                   mem_response_in,
    output logic [`XLEN-1:0]                   mem_addr_out,
    output logic [63:0]                        mem_data_out,
    output logic [1:0]                         mem_command_out,
    output logic [1:0]                         mem_size_out,
    output logic [IDX_W-1:0]                   grant_out,
    output logic                               orphan_err_out
);

    localparam int DEPTH = 2 ** TAG_W;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_starve;
    logic [NUM_REQ-1:0] w_pick_vec;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_start;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_lock_hit;
    logic               w_grant_valid;
    logic               w_accept;
    logic               w_alloc;
    MEM_OWNER_ENTRY     w_ret_entry;
    logic               w_ret_hit;
    logic               w_ret_orphan;

    logic               r_lock_valid;
    logic [IDX_W-1:0]   r_lock_idx;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant_last;
    logic               r_orphan;
    logic [7:0]         r_wait [NUM_REQ];
    MEM_OWNER_ENTRY     r_owner [DEPTH];

    // request decode, starvation detect and picker setup for the selected mode
    always_comb begin
        w_req    = '0;
        w_starve = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req[i]    = (req_command_in[i] != BUS_NONE);
            w_starve[i] = w_req[i] && (r_wait[i] == 8'(MAX_WAIT));
        end
        if (PRIO_MODE == 0) begin
            w_pick_vec   = (|w_starve) ? w_starve : w_req;
            w_pick_start = '0;
        end else begin
            w_pick_vec   = w_req;
            w_pick_start = r_rr_ptr;
        end
    end

    rr_priority_picker #(
        .N (NUM_REQ)
    ) u_picker (
        .i_req      (w_pick_vec),
        .i_start    (w_pick_start),
        .o_grant_oh (w_pick_oh),
        .o_valid    (w_pick_valid)
    );

    // a held (unaccepted) grant beats both arbitration modes
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pick_idx = w_pick_idx | (w_pick_oh[i] ? IDX_W'(i) : '0);
        end
        w_lock_hit    = r_lock_valid && w_req[r_lock_idx];
        w_grant_idx   = w_lock_hit ? r_lock_idx : w_pick_idx;
        w_grant_valid = w_lock_hit || w_pick_valid;
        w_accept      = w_grant_valid && (mem_response_in != '0);
        w_alloc       = w_accept && (req_command_in[w_grant_idx] == BUS_LOAD);
        grant_out     = w_grant_valid ? w_grant_idx : r_grant_last;
    end

    // same-cycle forwarding of the granted command and its accept tag
    always_comb begin
        mem_addr_out     = '0;
        mem_data_out     = 64'd0;
        mem_command_out  = BUS_NONE;
        mem_size_out     = DOUBLE;
        req_response_out = '0;
        if (w_grant_valid) begin
            mem_addr_out    = req_addr_in[w_grant_idx];
            mem_data_out    = (req_command_in[w_grant_idx] == BUS_STORE) ?
                              req_data_in[w_grant_idx] : 64'd0;
            mem_command_out = req_command_in[w_grant_idx];
            mem_size_out    = req_size_in[w_grant_idx];
            req_response_out[w_grant_idx] = mem_response_in;
        end else begin
            mem_command_out = BUS_NONE;
        end
    end

    // return steering uses the table contents before this cycle's update
    always_comb begin
        w_ret_entry  = r_owner[mem_tag_in];
        w_ret_hit    = (mem_tag_in != '0) && w_ret_entry.valid;
        w_ret_orphan = (mem_tag_in != '0) && !w_ret_entry.valid;
        req_tag_out  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data_out[i] = mem_data_in;
            if (w_ret_hit && (w_ret_entry.owner == MEM_OWNER_W'(i))) begin
                req_tag_out[i] = mem_tag_in;
            end else begin
                req_tag_out[i] = '0;
            end
        end
    end

    assign orphan_err_out = r_orphan;

    // lock, round-robin pointer, last grant and sticky orphan flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lock_valid <= 1'b0;
            r_lock_idx   <= '0;
            r_rr_ptr     <= '0;
            r_grant_last <= '0;
            r_orphan     <= 1'b0;
        end else begin
            r_lock_valid <= w_grant_valid && !w_accept;
            r_lock_idx   <= w_grant_idx;
            if (w_accept) begin
                r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ?
                            '0 : (w_grant_idx + IDX_W'(1));
            end
            if (w_grant_valid) begin
                r_grant_last <= w_grant_idx;
            end
            if (w_ret_orphan) begin
                r_orphan <= 1'b1;
            end
        end
    end

    // per-port starvation counters, only meaningful in fixed-priority mode
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset || (PRIO_MODE != 0)) begin
                r_wait[i] <= 8'd0;
            end else if (!w_req[i] || (w_grant_valid && (w_grant_idx == IDX_W'(i)))) begin
                r_wait[i] <= 8'd0;
            end else if (r_wait[i] < 8'(MAX_WAIT)) begin
                r_wait[i] <= r_wait[i] + 8'd1;
            end else begin
                r_wait[i] <= r_wait[i];
            end
        end
    end

    // owner table: a new allocation wins over a same-tag return clear
    always_ff @(posedge clock) begin
        for (int t = 0; t < DEPTH; t++) begin
            if (reset) begin
                r_owner[t] <= '0;
            end else if (w_alloc && (mem_response_in == TAG_W'(t))) begin
                r_owner[t] <= '{valid: 1'b1, owner: MEM_OWNER_W'(w_grant_idx)};
            end else if (w_ret_hit && (mem_tag_in == TAG_W'(t))) begin
                r_owner[t].valid <= 1'b0;
            end else begin
                r_owner[t] <= r_owner[t];
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Bench for mem_arbiter_nport: a fixed-priority instance (2 ports, MAX_WAIT=4)
// and a round-robin instance (4 ports), directed scenarios plus random traffic.
`ifndef XLEN
`define XLEN 64
`endif

module tb_mem_arbiter_nport;
    import sys_defs::*;

    localparam int MAXW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // stimulus, index 0 = fixed-priority DUT, 1 = round-robin DUT
    logic [1:0]  cmd  [2][4];
    logic [63:0] addr [2][4];
    logic [63:0] wdat [2][4];
    logic [1:0]  siz  [2][4];
    logic [3:0]  mtag [2];
    logic [3:0]  mresp[2];
    logic [63:0] mdat [2];

    // observed outputs in the same layout
    logic [3:0]  o_resp [2][4];
    logic [3:0]  o_tag  [2][4];
    logic [63:0] o_rdat [2][4];
    logic [63:0] o_maddr[2];
    logic [63:0] o_mdata[2];
    logic [1:0]  o_mcmd [2];
    logic [1:0]  o_msize[2];
    int          o_grant[2];
    logic        o_orph [2];

    logic [1:0][63:0] fx_addr, fx_wdat, fx_rdat;
    logic [1:0][1:0]  fx_cmd, fx_siz;
    logic [1:0][3:0]  fx_resp, fx_tag;
    logic [63:0]      fx_maddr, fx_mdata;
    logic [1:0]       fx_mcmd, fx_msize;
    logic             fx_grant, fx_orph;

    logic [3:0][63:0] rr_addr, rr_wdat, rr_rdat;
    logic [3:0][1:0]  rr_cmd, rr_siz;
    logic [3:0][3:0]  rr_resp, rr_tag;
    logic [63:0]      rr_maddr, rr_mdata;
    logic [1:0]       rr_mcmd, rr_msize;
    logic [1:0]       rr_grant;
    logic             rr_orph;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fx_addr[i] = addr[0][i]; fx_wdat[i] = wdat[0][i];
            fx_cmd[i]  = cmd[0][i];  fx_siz[i]  = siz[0][i];
        end
        for (int i = 0; i < 4; i++) begin
            rr_addr[i] = addr[1][i]; rr_wdat[i] = wdat[1][i];
            rr_cmd[i]  = cmd[1][i];  rr_siz[i]  = siz[1][i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            o_resp[0][i] = (i < 2) ? fx_resp[i[0]] : 4'd0;
            o_tag[0][i]  = (i < 2) ? fx_tag[i[0]]  : 4'd0;
            o_rdat[0][i] = (i < 2) ? fx_rdat[i[0]] : 64'd0;
            o_resp[1][i] = rr_resp[i[1:0]];
            o_tag[1][i]  = rr_tag[i[1:0]];
            o_rdat[1][i] = rr_rdat[i[1:0]];
        end
        o_maddr[0] = fx_maddr; o_mdata[0] = fx_mdata; o_mcmd[0] = fx_mcmd;
        o_msize[0] = fx_msize; o_grant[0] = int'(fx_grant); o_orph[0] = fx_orph;
        o_maddr[1] = rr_maddr; o_mdata[1] = rr_mdata; o_mcmd[1] = rr_mcmd;
        o_msize[1] = rr_msize; o_grant[1] = int'(rr_grant); o_orph[1] = rr_orph;
    end

    mem_arbiter_nport #(.NUM_REQ(2), .PRIO_MODE(0), .MAX_WAIT(MAXW), .TAG_W(4)) dut_fx (
        .clock(clock), .reset(reset),
        .req_addr_in(fx_addr), .req_data_in(fx_wdat), .req_command_in(fx_cmd),
        .req_size_in(fx_siz), .req_response_out(fx_resp), .req_tag_out(fx_tag),
        .req_data_out(fx_rdat), .mem_tag_in(mtag[0]), .mem_data_in(mdat[0]),
        .mem_response_in(mresp[0]), .mem_addr_out(fx_maddr), .mem_data_out(fx_mdata),
        .mem_command_out(fx_mcmd), .mem_size_out(fx_msize), .grant_out(fx_grant),
        .orphan_err_out(fx_orph)
    );

    mem_arbiter_nport #(.NUM_REQ(4), .PRIO_MODE(1), .MAX_WAIT(8), .TAG_W(4)) dut_rr (
        .clock(clock), .reset(reset),
        .req_addr_in(rr_addr), .req_data_in(rr_wdat), .req_command_in(rr_cmd),
        .req_size_in(rr_siz), .req_response_out(rr_resp), .req_tag_out(rr_tag),
        .req_data_out(rr_rdat), .mem_tag_in(mtag[1]), .mem_data_in(mdat[1]),
        .mem_response_in(mresp[1]), .mem_addr_out(rr_maddr), .mem_data_out(rr_mdata),
        .mem_command_out(rr_mcmd), .mem_size_out(rr_msize), .grant_out(rr_grant),
        .orphan_err_out(rr_orph)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model: ownership map, pending (unaccepted) grant, wait ages
    int m_lock_v [2];
    int m_lock_i [2];
    int m_wait   [2][4];
    int m_ptr    [2];
    int m_last   [2];
    int m_ov     [2][16];
    int m_own    [2][16];
    int m_orph   [2];

    function automatic int nr(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic model_grant(input int d, output int g, output bit v);
        int i;
        g = 0;
        v = 1'b0;
        if (m_lock_v[d] != 0 && cmd[d][m_lock_i[d]] != 2'd0) begin
            g = m_lock_i[d];
            v = 1'b1;
        end else if (d == 0) begin
            for (int k = 0; k < nr(d); k++)
                if (!v && cmd[d][k] != 2'd0 && m_wait[d][k] == MAXW) begin g = k; v = 1'b1; end
            for (int k = 0; k < nr(d); k++)
                if (!v && cmd[d][k] != 2'd0) begin g = k; v = 1'b1; end
        end else begin
            for (int k = 0; k < nr(d); k++) begin
                i = (m_ptr[d] + k) % nr(d);
                if (!v && cmd[d][i] != 2'd0) begin g = i; v = 1'b1; end
            end
        end
    endtask

    task automatic check_outputs(input int d);
        int g;
        bit v;
        int t;
        model_grant(d, g, v);
        t = int'(mtag[d]);
        check_eq($sformatf("d%0d grant", d), 64'(o_grant[d]), v ? 64'(g) : 64'(m_last[d]));
        check_eq($sformatf("d%0d mem_cmd", d), 64'(o_mcmd[d]), v ? 64'(cmd[d][g]) : 64'd0);
        check_eq($sformatf("d%0d mem_addr", d), o_maddr[d], v ? addr[d][g] : 64'd0);
        check_eq($sformatf("d%0d mem_data", d), o_mdata[d],
                 (v && cmd[d][g] == 2'd2) ? wdat[d][g] : 64'd0);
        check_eq($sformatf("d%0d mem_size", d), 64'(o_msize[d]), v ? 64'(siz[d][g]) : 64'd3);
        for (int i = 0; i < nr(d); i++) begin
            check_eq($sformatf("d%0d resp%0d", d, i), 64'(o_resp[d][i]),
                     (v && i == g) ? 64'(mresp[d]) : 64'd0);
            check_eq($sformatf("d%0d tag%0d", d, i), 64'(o_tag[d][i]),
                     (t != 0 && m_ov[d][t] != 0 && m_own[d][t] == i) ? 64'(t) : 64'd0);
            check_eq($sformatf("d%0d rdata%0d", d, i), o_rdat[d][i], mdat[d]);
        end
        check_eq($sformatf("d%0d orphan", d), 64'(o_orph[d]), 64'(m_orph[d]));
    endtask

    task automatic model_update(input int d);
        int g;
        bit v;
        bit acc;
        int t;
        int r;
        if (reset) begin
            m_lock_v[d] = 0; m_lock_i[d] = 0; m_ptr[d] = 0; m_last[d] = 0; m_orph[d] = 0;
            for (int i = 0; i < 4; i++) m_wait[d][i] = 0;
            for (int k = 0; k < 16; k++) m_ov[d][k] = 0;
        end else begin
            model_grant(d, g, v);
            acc = v && (mresp[d] != 4'd0);
            t   = int'(mtag[d]);
            r   = int'(mresp[d]);
            if (t != 0) begin
                if (m_ov[d][t] != 0) m_ov[d][t] = 0;
                else m_orph[d] = 1;
            end
            if (acc && cmd[d][g] == 2'd1) begin
                m_ov[d][r]  = 1;
                m_own[d][r] = g;
            end
            m_lock_v[d] = (v && !acc) ? 1 : 0;
            m_lock_i[d] = g;
            for (int i = 0; i < nr(d); i++) begin
                if (cmd[d][i] == 2'd0 || (v && g == i)) m_wait[d][i] = 0;
                else if (m_wait[d][i] < MAXW) m_wait[d][i] = m_wait[d][i] + 1;
            end
            if (acc) m_ptr[d] = (g + 1) % nr(d);
            if (v) m_last[d] = g;
        end
    endtask

    task automatic settle();
        #4;
        if (reset == 1'b0) begin
            check_outputs(0);
            check_outputs(1);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_update(0);
        model_update(1);
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                cmd[d][i] = 2'd0; addr[d][i] = 64'd0; wdat[d][i] = 64'd0; siz[d][i] = 2'd0;
            end
            mtag[d] = 4'd0; mresp[d] = 4'd0; mdat[d] = 64'd0;
        end
    endtask

    task automatic rand_inputs(input int d);
        int r;
        int t;
        for (int i = 0; i < 4; i++) begin
            r = int'($urandom_range(0, 9));
            cmd[d][i]  = (i >= nr(d)) ? 2'd0 : (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : 2'd2;
            addr[d][i] = {$urandom, $urandom};
            wdat[d][i] = {$urandom, $urandom};
            siz[d][i]  = 2'($urandom_range(0, 3));
        end
        mresp[d] = 4'd0;
        if ($urandom_range(0, 9) < 7) begin
            for (int k = 0; k < 8; k++) begin
                t = int'($urandom_range(1, 15));
                if (mresp[d] == 4'd0 && m_ov[d][t] == 0) mresp[d] = 4'(t);
            end
        end
        mtag[d] = 4'd0;
        if ($urandom_range(0, 9) < 4) begin
            for (int k = 0; k < 8; k++) begin
                t = int'($urandom_range(1, 15));
                if (mtag[d] == 4'd0 && m_ov[d][t] != 0) mtag[d] = 4'(t);
            end
        end
        mdat[d] = {$urandom, $urandom};
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int exp_rr [10];
        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 2, 2, 3};
        idle();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;

        settle();
        check_eq("rst grant fx", 64'(o_grant[0]), 64'd0);
        check_eq("rst grant rr", 64'(o_grant[1]), 64'd0);
        check_eq("rst orphan fx", 64'(o_orph[0]), 64'd0);
        check_eq("rst size idle", 64'(o_msize[0]), 64'd3);
        tick();

        // two loads contend, port 0 wins and gets accept tag 3
        cmd[0][0] = 2'd1; addr[0][0] = 64'h100;
        cmd[0][1] = 2'd1; addr[0][1] = 64'h200;
        mresp[0] = 4'd3;
        settle();
        check_eq("fx addr", o_maddr[0], 64'h100);
        check_eq("fx resp0", 64'(o_resp[0][0]), 64'd3);
        check_eq("fx resp1", 64'(o_resp[0][1]), 64'd0);
        tick();
        idle();
        mtag[0] = 4'd3; mdat[0] = 64'hDEAD;
        settle();
        check_eq("fx ret tag0", 64'(o_tag[0][0]), 64'd3);
        check_eq("fx ret tag1", 64'(o_tag[0][1]), 64'd0);
        check_eq("fx ret data", o_rdat[0][0], 64'hDEAD);
        tick();
        idle();

        // starvation override after MAX_WAIT ungranted cycles
        for (int k = 1; k <= 6; k++) begin
            cmd[0][0] = 2'd2; cmd[0][1] = 2'd2;
            mresp[0] = 4'(k);
            settle();
            check_eq($sformatf("starve grant c%0d", k), 64'(o_grant[0]), (k == 5) ? 64'd1 : 64'd0);
            tick();
        end
        idle();

        // round-robin rotation, then a held grant on port 2
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 4; i++) cmd[1][i] = 2'd2;
            mresp[1] = (k == 6 || k == 7) ? 4'd0 : 4'd1;
            settle();
            check_eq($sformatf("rr grant c%0d", k), 64'(o_grant[1]), 64'(exp_rr[k]));
            tick();
        end
        idle();

        // same-cycle reuse of tag 5
        cmd[0][1] = 2'd1; mresp[0] = 4'd5;
        cyc();
        idle();
        cmd[0][0] = 2'd1; mresp[0] = 4'd5; mtag[0] = 4'd5;
        settle();
        check_eq("reuse old owner", 64'(o_tag[0][1]), 64'd5);
        check_eq("reuse not new", 64'(o_tag[0][0]), 64'd0);
        tick();
        idle();
        mtag[0] = 4'd5;
        settle();
        check_eq("reuse new owner", 64'(o_tag[0][0]), 64'd5);
        check_eq("reuse old cleared", 64'(o_tag[0][1]), 64'd0);
        tick();
        idle();

        // orphan return is flagged and sticky
        mtag[0] = 4'd7;
        settle();
        check_eq("orphan tag0", 64'(o_tag[0][0]), 64'd0);
        check_eq("orphan tag1", 64'(o_tag[0][1]), 64'd0);
        tick();
        idle();
        repeat (3) cyc();
        settle();
        check_eq("orphan sticky", 64'(o_orph[0]), 64'd1);
        tick();

        for (int n = 0; n < 400; n++) begin
            rand_inputs(0);
            rand_inputs(1);
            cyc();
        end

        // reset while a load is outstanding
        idle();
        cmd[1][0] = 2'd1; mresp[1] = 4'd2;
        cyc();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        mtag[1] = 4'd2;
        settle();
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("post-reset tag%0d", i), 64'(o_tag[1][i]), 64'd0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) cmd[1][i] = 2'd2;
        mresp[1] = 4'd1;
        settle();
        check_eq("post-reset orphan rr", 64'(o_orph[1]), 64'd1);
        check_eq("post-reset orphan fx", 64'(o_orph[0]), 64'd0);
        check_eq("post-reset rr_ptr", 64'(o_grant[1]), 64'd0);
        tick();
        idle();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
